// File: rtl/instr_sequencer_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
interface instr_sequencer_if #(
  parameter int unsigned OPW = 5
);

  // Status from the datapath
  logic           Stop;
  logic [31:0]    IR;
  logic           CON_FF;

  // Bus drivers
  logic           PCout;
  logic           Zlowout;
  logic           MDRout;
  logic           Cout;
  logic           BAout;
  logic           Rout;

  // Register load enables
  logic           MARin;
  logic           MDRin;
  logic           IRin;
  logic           Yin;
  logic           Zin;
  logic           PCin;
  logic           Rin;
  logic           CON_in;

  // PC increment and memory strobes
  logic           IncPC;
  logic           Read;
  logic           Write;

  // Register-field selects
  logic           Gra;
  logic           Grb;
  logic           Grc;

  // Unused drivers in this revision
  logic           HIout;
  logic           LOout;
  logic           ZHighout;
  logic           InPortout;

  logic [OPW-1:0] operation;
  logic           Run;

  modport master (
    input  Stop, IR, CON_FF,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output MARin, MDRin, IRin, Yin, Zin, PCin, Rin, CON_in,
    output IncPC, Read, Write,
    output Gra, Grb, Grc,
    output HIout, LOout, ZHighout, InPortout,
    output operation, Run
  );

  modport slave (
    output Stop, IR, CON_FF,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  MARin, MDRin, IRin, Yin, Zin, PCin, Rin, CON_in,
    input  IncPC, Read, Write,
    input  Gra, Grb, Grc,
    input  HIout, LOout, ZHighout, InPortout,
    input  operation, Run
  );

endinterface

// File: rtl/instr_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, per-opcode execute in T3-T7.
// All strobes come from a register loaded with the decode of the next state,
// so nothing toggles mid-cycle.
module instr_sequencer #(
  parameter int unsigned OPW = 5
) (
  input logic               Clock,
  input logic               Reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  typedef struct packed {
    logic           pc_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           c_out;
    logic           ba_out;
    logic           r_out;
    logic           mar_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           z_in;
    logic           pc_in;
    logic           r_in;
    logic           con_in;
    logic           inc_pc;
    logic           read;
    logic           write;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           run;
    logic [OPW-1:0] operation;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);

  // ALU code used for every address calculation
  localparam logic [OPW-1:0] ALU_ADD = OP_ADD;

  state_t         state;
  state_t         state_nxt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_nxt;
  logic [OPW-1:0] ir_op;
  ctrl_t          ctrl_q;
  logic           unused_ir;

  // add..rol: ALU code is the opcode itself
  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_itype(input logic [OPW-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Opcodes that have at least one execute step
  function automatic logic has_exec(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) || is_rtype(op) ||
           is_itype(op) || (op == OP_BR) || (op == OP_JR);
  endfunction

  // ALU select for the immediate forms
  function automatic logic [OPW-1:0] imm_alu(input logic [OPW-1:0] op);
    logic [OPW-1:0] a;
    a = ALU_ADD;
    if (op == OP_ANDI) a = OP_AND;
    if (op == OP_ORI)  a = OP_OR;
    return a;
  endfunction

  // True when execute step s is the instruction boundary for op
  function automatic logic is_last(input state_t s, input logic [OPW-1:0] op);
    logic last;
    last = 1'b0;
    case (s)
      S_T3:    last = (op == OP_JR);
      S_T5:    last = (op == OP_LDI) || is_rtype(op) || is_itype(op);
      S_T6:    last = (op == OP_BR);
      S_T7:    last = 1'b1;
      default: last = 1'b0;
    endcase
    return last;
  endfunction

  // Successor state; exec_op is the latched opcode, new_op the one arriving in IR
  function automatic state_t next_state(input state_t s, input logic [OPW-1:0] exec_op,
                                        input logic [OPW-1:0] new_op, input logic stop);
    state_t n;
    n = s;
    case (s)
      S_RST: n = S_T0;
      S_T0:  n = S_T1;
      S_T1:  n = S_T2;
      S_T2: begin
        if (new_op == OP_NOP)     n = stop ? S_HALT : S_T0;
        else if (has_exec(new_op)) n = S_T3;
        else                       n = S_HALT;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (is_last(s, exec_op)) begin
          n = stop ? S_HALT : S_T0;
        end else begin
          case (s)
            S_T3:    n = S_T4;
            S_T4:    n = S_T5;
            S_T5:    n = S_T6;
            S_T6:    n = S_T7;
            default: n = S_HALT;
          endcase
        end
      end
      S_HALT:  n = S_HALT;
      default: n = S_HALT;
    endcase
    return n;
  endfunction

  // Strobe pattern for a step; con only matters in the branch-taken step
  function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op, input logic con);
    ctrl_t c;
    c     = '0;
    c.run = (s != S_RST) && (s != S_HALT);
    case (s)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      S_T1: begin
        c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        if ((op == OP_LD) || (op == OP_LDI) || (op == OP_ST)) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end else if (is_rtype(op) || is_itype(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (op == OP_BR) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
        end else if (op == OP_JR) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
        end
      end
      S_T4: begin
        if ((op == OP_LD) || (op == OP_LDI) || (op == OP_ST)) begin
          c.c_out = 1'b1; c.z_in = 1'b1; c.operation = ALU_ADD;
        end else if (is_rtype(op)) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.operation = op;
        end else if (is_itype(op)) begin
          c.c_out = 1'b1; c.z_in = 1'b1; c.operation = imm_alu(op);
        end else if (op == OP_BR) begin
          c.pc_out = 1'b1; c.y_in = 1'b1;
        end
      end
      S_T5: begin
        if ((op == OP_LD) || (op == OP_ST)) begin
          c.zlow_out = 1'b1; c.mar_in = 1'b1;
        end else if ((op == OP_LDI) || is_rtype(op) || is_itype(op)) begin
          c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (op == OP_BR) begin
          c.c_out = 1'b1; c.z_in = 1'b1; c.operation = ALU_ADD;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          c.read = 1'b1; c.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
        end else if ((op == OP_BR) && con) begin
          c.zlow_out = 1'b1; c.pc_in = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (op == OP_ST) begin
          c.write = 1'b1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Opcode field, latched only on the T2->T3 edge
  assign ir_op     = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];
  assign op_nxt    = (state == S_T2) ? ir_op : op_q;
  assign state_nxt = next_state(state, op_q, ir_op, bus.Stop);

  // State, latched opcode and registered strobes; Reset wins over everything
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_RST;
      op_q   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      ctrl_q <= decode(state_nxt, op_nxt, bus.CON_FF);
    end
  end

  assign bus.PCout     = ctrl_q.pc_out;
  assign bus.Zlowout   = ctrl_q.zlow_out;
  assign bus.MDRout    = ctrl_q.mdr_out;
  assign bus.Cout      = ctrl_q.c_out;
  assign bus.BAout     = ctrl_q.ba_out;
  assign bus.Rout      = ctrl_q.r_out;
  assign bus.MARin     = ctrl_q.mar_in;
  assign bus.MDRin     = ctrl_q.mdr_in;
  assign bus.IRin      = ctrl_q.ir_in;
  assign bus.Yin       = ctrl_q.y_in;
  assign bus.Zin       = ctrl_q.z_in;
  assign bus.PCin      = ctrl_q.pc_in;
  assign bus.Rin       = ctrl_q.r_in;
  assign bus.CON_in    = ctrl_q.con_in;
  assign bus.IncPC     = ctrl_q.inc_pc;
  assign bus.Read      = ctrl_q.read;
  assign bus.Write     = ctrl_q.write;
  assign bus.Gra       = ctrl_q.gra;
  assign bus.Grb       = ctrl_q.grb;
  assign bus.Grc       = ctrl_q.grc;
  assign bus.operation = ctrl_q.operation;
  assign bus.Run       = ctrl_q.run;

  assign bus.HIout     = 1'b0;
  assign bus.LOout     = 1'b0;
  assign bus.ZHighout  = 1'b0;
  assign bus.InPortout = 1'b0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected step vectors are queued when an
// instruction is presented and popped one per cycle against the DUT strobes.
module tb_instr_sequencer;

  logic Clock = 1'b0;
  logic Reset;

  instr_sequencer_if #(.OPW(5)) bus ();

  instr_sequencer #(.OPW(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Observed vector: 24 strobes, Run, operation
  logic [29:0] obs;
  assign obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.BAout, bus.Rout,
                bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.PCin, bus.Rin,
                bus.CON_in, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc,
                bus.HIout, bus.LOout, bus.ZHighout, bus.InPortout, bus.Run, bus.operation};

  localparam logic [29:0] M_PCOUT  = 30'(1) << 29;
  localparam logic [29:0] M_ZLOW   = 30'(1) << 28;
  localparam logic [29:0] M_MDROUT = 30'(1) << 27;
  localparam logic [29:0] M_COUT   = 30'(1) << 26;
  localparam logic [29:0] M_BAOUT  = 30'(1) << 25;
  localparam logic [29:0] M_ROUT   = 30'(1) << 24;
  localparam logic [29:0] M_MARIN  = 30'(1) << 23;
  localparam logic [29:0] M_MDRIN  = 30'(1) << 22;
  localparam logic [29:0] M_IRIN   = 30'(1) << 21;
  localparam logic [29:0] M_YIN    = 30'(1) << 20;
  localparam logic [29:0] M_ZIN    = 30'(1) << 19;
  localparam logic [29:0] M_PCIN   = 30'(1) << 18;
  localparam logic [29:0] M_RIN    = 30'(1) << 17;
  localparam logic [29:0] M_CONIN  = 30'(1) << 16;
  localparam logic [29:0] M_INCPC  = 30'(1) << 15;
  localparam logic [29:0] M_READ   = 30'(1) << 14;
  localparam logic [29:0] M_WRITE  = 30'(1) << 13;
  localparam logic [29:0] M_GRA    = 30'(1) << 12;
  localparam logic [29:0] M_GRB    = 30'(1) << 11;
  localparam logic [29:0] M_GRC    = 30'(1) << 10;
  localparam logic [29:0] M_RUN    = 30'(1) << 5;

  localparam logic [29:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;

  logic [29:0] sb[$];
  int          n_err;
  int          n_checks;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Push one running step (Run is implied)
  function automatic void sbp(input logic [29:0] v);
    sb.push_back(v | M_RUN);
  endfunction

  // Reference step sequence for one instruction, straight from the opcode table
  function automatic void push_instr(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    sbp(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    sbp(M_ZLOW | M_PCIN | M_READ | M_MDRIN);
    sbp(M_MDROUT | M_IRIN);
    case (op)
      5'b00000: begin // ld
        sbp(M_GRB | M_BAOUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd3);
        sbp(M_ZLOW | M_MARIN);
        sbp(M_READ | M_MDRIN);
        sbp(M_MDROUT | M_GRA | M_RIN);
      end
      5'b00001: begin // ldi
        sbp(M_GRB | M_BAOUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd3);
        sbp(M_ZLOW | M_GRA | M_RIN);
      end
      5'b00010: begin // st
        sbp(M_GRB | M_BAOUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd3);
        sbp(M_ZLOW | M_MARIN);
        sbp(M_GRA | M_ROUT | M_MDRIN);
        sbp(M_WRITE);
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010: begin // R-type
        sbp(M_GRB | M_ROUT | M_YIN);
        sbp(M_GRC | M_ROUT | M_ZIN | 30'(op));
        sbp(M_ZLOW | M_GRA | M_RIN);
      end
      5'b01011: begin // addi
        sbp(M_GRB | M_ROUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd3);
        sbp(M_ZLOW | M_GRA | M_RIN);
      end
      5'b01100: begin // andi
        sbp(M_GRB | M_ROUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd5);
        sbp(M_ZLOW | M_GRA | M_RIN);
      end
      5'b01101: begin // ori
        sbp(M_GRB | M_ROUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd6);
        sbp(M_ZLOW | M_GRA | M_RIN);
      end
      5'b10010: begin // br
        sbp(M_GRA | M_ROUT | M_CONIN);
        sbp(M_PCOUT | M_YIN);
        sbp(M_COUT | M_ZIN | 30'd3);
        sbp(con ? (M_ZLOW | M_PCIN) : 30'd0);
      end
      5'b10011: sbp(M_GRA | M_ROUT | M_PCIN); // jr
      default: ; // nop, halt, undefined: fetch only
    endcase
  endfunction

  // Pop one expected vector per cycle; optionally raise Stop from a step on and
  // measure cycles until the next T0
  task automatic drive_and_check(input string tag, input int stop_step, input int exp_period);
    int n;
    int per;
    logic [29:0] e;
    n   = sb.size();
    per = -1;
    for (int k = 0; k < n; k++) begin
      bus.Stop = (stop_step >= 0) && (k >= stop_step);
      if (k > 0 && per < 0 && obs == V_T0) per = k;
      e = sb.pop_front();
      check_eq($sformatf("%s_s%0d", tag, k), 32'(obs), 32'(e));
      @(posedge Clock); #1;
    end
    bus.Stop = 1'b0;
    if (exp_period > 0) begin
      for (int x = 0; x < 20 && per < 0; x++) begin
        if (obs == V_T0) per = n + x;
        else begin
          @(posedge Clock); #1;
        end
      end
      check_eq({tag, "_period"}, 32'(per), 32'(exp_period));
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                           input int period);
    bus.IR     = ir;
    bus.CON_FF = con;
    push_instr(ir, con);
    drive_and_check(tag, -1, period);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check_eq({tag, "_rst"}, 32'(obs), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check_eq({tag, "_t0"}, 32'(obs), 32'(V_T0));
  endtask

  task automatic run_halt(input string tag, input logic [31:0] ir);
    bus.IR = ir;
    push_instr(ir, 1'b0);
    repeat (20) sb.push_back(30'd0);
    drive_and_check(tag, -1, 0);
    do_reset(tag);
  endtask

  initial begin
    n_err      = 0;
    n_checks   = 0;
    Reset      = 1'b1;
    bus.Stop   = 1'b0;
    bus.IR     = 32'h0;
    bus.CON_FF = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_eq("reset_state", 32'(obs), 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check_eq("reset_t0", 32'(obs), 32'(V_T0));

    // ld abandoned at T5 by Reset
    bus.IR = 32'h02000054;
    push_instr(32'h02000054, 1'b0);
    while (sb.size() > 5) void'(sb.pop_back());
    drive_and_check("ld_abort", -1, 0);
    check_eq("ld_abort_t5", 32'(obs), 32'(M_ZLOW | M_MARIN | M_RUN));
    do_reset("ld_abort");

    run_instr("ld",    32'h02000054, 1'b0, 8);
    run_instr("st",    32'h10000010, 1'b0, 8);
    run_instr("ldi",   32'h08800005, 1'b0, 6);
    run_instr("add",   32'h18918000, 1'b0, 6);
    run_instr("sub",   32'h20918000, 1'b0, 6);
    run_instr("rol",   32'h50918000, 1'b0, 6);
    run_instr("addi",  32'h58900007, 1'b0, 6);
    run_instr("andi",  32'h60900007, 1'b0, 6);
    run_instr("ori",   32'h68900007, 1'b0, 6);
    run_instr("br_t",  32'h90000000, 1'b1, 7);
    run_instr("br_nt", 32'h90000000, 1'b0, 7);
    run_instr("jr",    32'h9A800000, 1'b0, 4);
    run_instr("nop",   32'hD0000000, 1'b0, 3);

    // Stop raised in T4 of add: ignored there, honoured at the T5 boundary
    bus.IR = 32'h18918000;
    push_instr(32'h18918000, 1'b0);
    repeat (5) sb.push_back(30'd0);
    drive_and_check("add_stop", 4, 0);
    do_reset("add_stop");

    run_halt("halt",  32'hD8000000);
    run_halt("undef", 32'hF8000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
